lsu_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane.sv | 39 +++
 rtl/lsu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states, RD counter sizing.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  // Encodings 10 and 11 both mean a full word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: load extraction/extension and sub-word store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] mdata
);

  logic [15:0] hw;
  logic [7:0]  bt;
  logic [4:0]  lsb;

  always_comb begin
    hw    = '0;
    bt    = '0;
    lsb   = {offset, 3'b000};
    rdata = '0;
    mdata = word;
    if (is_word(size)) begin
      rdata = word;
      mdata = wdata;
    end else if (size == SZ_H) begin
      hw    = offset[1] ? word[31:16] : word[15:0];
      rdata = {{16{sgn & hw[15]}}, hw};
      if (offset[1]) mdata[31:16] = wdata[15:0];
      else           mdata[15:0]  = wdata[15:0];
    end else begin
      bt              = word[lsb +: 8];
      rdata           = {{24{sgn & bt[7]}}, bt};
      mdata[lsb +: 8] = wdata[7:0];
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator for the word-organised data memory, with read-modify-write for sub-word stores.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned WADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [WADDR_W+1:0]   req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [WADDR_W-1:0]   mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned AW = WADDR_W + 2;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, sgn_q;
  logic [1:0]         size_q, off_q;
  logic [31:0]        wdata_q;
  logic               accept;
  logic               misal;
  logic [AW-1:0]      aligned;

  logic               mem_read_d, mem_write_d, rsp_valid_d, rsp_err_d;
  logic [WADDR_W-1:0] mem_addr_d;
  logic [31:0]        mem_wdata_d, rsp_rdata_d;
  logic [31:0]        lane_rdata, lane_mdata;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Alignment handling: trap misaligned requests, or silently clear the offending offset bits.
  always_comb begin
    aligned = req_addr;
    misal   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = ((req_size == SZ_H) && req_addr[0]) ||
            (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == SZ_H)       aligned[0]   = 1'b0;
    else if (is_word(req_size)) aligned[1:0] = 2'b00;
`endif
  end

  lsu_lane u_lane (
    .word   (mem_rdata),
    .size   (size_q),
    .offset (off_q),
    .sgn    (sgn_q),
    .wdata  (wdata_q),
    .rdata  (lane_rdata),
    .mdata  (lane_mdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!req_we || !is_word(req_size)) begin
            state_d    = RD;
            cnt_d      = '0;
            mem_read_d = 1'b1;
            mem_addr_d = aligned[AW-1:2];
          end else begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_addr_d  = aligned[AW-1:2];
            mem_wdata_d = req_wdata;
          end
        end
      end
      RD: begin
        // mem_rdata is consumed on the edge that closes the last read cycle.
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          mem_read_d = 1'b0;
          if (we_q) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = lane_mdata;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lane_rdata;
            rsp_err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request attributes held for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      sgn_q   <= req_signed;
      size_q  <= req_size;
      off_q   <= aligned[1:0];
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3, each with a word memory.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, req_signed, rsp_ready;
  logic [1:0]  req_size;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;

  logic        req_ready1, rsp_valid1, rsp_err1, mem_read1, mem_write1;
  logic [31:0] rsp_rdata1, mem_wdata1, mem_rdata1;
  logic [4:0]  mem_addr1;
  logic        req_ready3, rsp_valid3, rsp_err3, mem_read3, mem_write3;
  logic [31:0] rsp_rdata3, mem_wdata3, mem_rdata3;
  logic [4:0]  mem_addr3;

  logic [31:0] mem1 [32];
  logic [31:0] mem3 [32];

  int n_chk  = 0;
  int n_pass = 0;
  int wr_total = 0;
  logic both_seen = 1'b0;

  int          r_lat, r_nrd, r_nwr, r_rd_at, r_wr_at;
  logic [31:0] r_rdata, r_wdata;
  logic        r_err, r_stable;
  logic [4:0]  r_waddr, r_raddr;

  always #5 clk = ~clk;

  lsu_ctrl #(.RD_LAT(1), .WADDR_W(5)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(req_ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_rdata(mem_rdata1)
  );

  lsu_ctrl #(.RD_LAT(3), .WADDR_W(5)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(req_ready3),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_rdata(mem_rdata3)
  );

  assign mem_rdata1 = mem1[mem_addr1];
  assign mem_rdata3 = mem3[mem_addr3];

  always @(posedge clk) begin
    if (mem_write1) begin
      mem1[mem_addr1] <= mem_wdata1;
      wr_total <= wr_total + 1;
    end
    if (mem_write3) mem3[mem_addr3] <= mem_wdata3;
  end

  always @(negedge clk)
    if ((mem_read1 && mem_write1) || (mem_read3 && mem_write3)) both_seen <= 1'b1;

  wire        o_ready = sel ? req_ready3 : req_ready1;
  wire        o_rv    = sel ? rsp_valid3 : rsp_valid1;
  wire [31:0] o_rd    = sel ? rsp_rdata3 : rsp_rdata1;
  wire        o_err   = sel ? rsp_err3   : rsp_err1;
  wire        o_mrd   = sel ? mem_read3  : mem_read1;
  wire        o_mwr   = sel ? mem_write3 : mem_write1;
  wire [4:0]  o_maddr = sel ? mem_addr3  : mem_addr1;
  wire [31:0] o_mwd   = sel ? mem_wdata3 : mem_wdata1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // One request; cycle k counts negedges after the accept edge. Response held off for 'hold' cycles.
  task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [6:0] a, input logic [31:0] wd, input int hold);
    int k;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_rd_at = 0; r_wr_at = 0;
    r_rdata = '0; r_wdata = '0; r_err = 1'b0; r_stable = 1'b1;
    r_waddr = '0; r_raddr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (r_lat == 0 && k < 30) begin
      @(negedge clk);
      k++;
      if (o_mrd) begin
        r_nrd++;
        if (r_rd_at == 0) r_rd_at = k;
        r_raddr = o_maddr;
      end
      if (o_mwr) begin
        r_nwr++;
        if (r_wr_at == 0) r_wr_at = k;
        r_wdata = o_mwd;
        r_waddr = o_maddr;
      end
      if (o_rv) begin
        r_lat = k; r_rdata = o_rd; r_err = o_err;
      end
    end
    if (r_lat != 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!o_rv || o_rd !== r_rdata || o_err !== r_err || o_ready) r_stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  int wr_before;

  initial begin
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready1), 0);
    check("rst_rsp_valid", 32'(rsp_valid1), 0);
    check("rst_strobes", 32'({mem_read1, mem_write1}), 0);
    check("rst_mem_addr", 32'(mem_addr1), 0);
    check("rst_rsp_rdata", rsp_rdata1, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready1), 1);

    // Word store then word load at byte 0x08.
    txn(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 0);
    check("wst_wr_at", 32'(r_wr_at), 1);
    check("wst_addr", 32'(r_waddr), 2);
    check("wst_wdata", r_wdata, 32'hDEADBEEF);
    check("wst_nrd", 32'(r_nrd), 0);
    check("wst_lat", 32'(r_lat), 2);
    check("wst_rdata", r_rdata, 0);
    txn(1'b0, 2'b10, 1'b0, 7'h08, '0, 0);
    check("wld_rd_at", 32'(r_rd_at), 1);
    check("wld_raddr", 32'(r_raddr), 2);
    check("wld_lat", 32'(r_lat), 2);
    check("wld_rdata", r_rdata, 32'hDEADBEEF);
    check("wld_err", 32'(r_err), 0);

    // Extraction / extension over 0x80FF7F01.
    txn(1'b1, 2'b10, 1'b0, 7'h08, 32'h80FF7F01, 0);
    txn(1'b0, 2'b00, 1'b1, 7'h0B, '0, 0);
    check("ldb_s_0b", r_rdata, 32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b0, 7'h0A, '0, 0);
    check("ldb_u_0a", r_rdata, 32'h000000FF);
    txn(1'b0, 2'b01, 1'b1, 7'h08, '0, 0);
    check("ldh_s_08", r_rdata, 32'h00007F01);
    txn(1'b0, 2'b01, 1'b1, 7'h0A, '0, 0);
    check("ldh_s_0a", r_rdata, 32'hFFFF80FF);
    txn(1'b0, 2'b11, 1'b1, 7'h08, '0, 0);
    check("ldw_sz11", r_rdata, 32'h80FF7F01);

    // Sub-word stores: read-modify-write.
    txn(1'b1, 2'b10, 1'b0, 7'h08, 32'h11223344, 0);
    txn(1'b1, 2'b00, 1'b0, 7'h09, 32'h000000AA, 0);
    check("stb_rd_at", 32'(r_rd_at), 1);
    check("stb_wr_at", 32'(r_wr_at), 2);
    check("stb_lat", 32'(r_lat), 3);
    check("stb_counts", 32'({r_nrd[3:0], r_nwr[3:0]}), 32'h11);
    check("stb_wdata", r_wdata, 32'h1122AA44);
    check("stb_mem", mem1[2], 32'h1122AA44);
    txn(1'b1, 2'b01, 1'b0, 7'h0A, 32'h0000BEEF, 0);
    check("sth_wdata", r_wdata, 32'hBEEFAA44);
    check("sth_rdata", r_rdata, 0);

    // Misaligned accesses.
    txn(1'b1, 2'b10, 1'b0, 7'h04, 32'hCAFE1234, 0);
    txn(1'b0, 2'b01, 1'b0, 7'h05, '0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_h_lat", 32'(r_lat), 1);
    check("mis_h_err", 32'(r_err), 1);
    check("mis_h_rdata", r_rdata, 0);
    check("mis_h_strobes", 32'(r_nrd + r_nwr), 0);
`else
    check("mis_h_lat", 32'(r_lat), 2);
    check("mis_h_err", 32'(r_err), 0);
    check("mis_h_rdata", r_rdata, 32'h00001234);
    check("mis_h_raddr", 32'(r_raddr), 1);
`endif
    txn(1'b0, 2'b10, 1'b1, 7'h07, '0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_w_err", 32'(r_err), 1);
    check("mis_w_lat", 32'(r_lat), 1);
`else
    check("mis_w_err", 32'(r_err), 0);
    check("mis_w_rdata", r_rdata, 32'hCAFE1234);
`endif

    // RD_LAT=3 instance with a stalled response.
    sel = 1'b1;
    txn(1'b1, 2'b10, 1'b0, 7'h10, 32'h13579BDF, 0);
    check("l3_wst_lat", 32'(r_lat), 2);
    txn(1'b0, 2'b10, 1'b0, 7'h10, '0, 5);
    check("l3_rd_at", 32'(r_rd_at), 1);
    check("l3_nrd", 32'(r_nrd), 3);
    check("l3_lat", 32'(r_lat), 4);
    check("l3_rdata", r_rdata, 32'h13579BDF);
    check("l3_stable", 32'(r_stable), 1);
    sel = 1'b0;

    // Reset during the read phase of a byte store.
    wr_before = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 7'h08; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mrst_rd_pre", 32'(mem_read1), 1);
    #1 reset = 1'b1;
    #1;
    check("mrst_rd_drop", 32'(mem_read1), 0);
    check("mrst_wr_drop", 32'(mem_write1), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_ready", 32'(req_ready1), 1);
    check("mrst_rsp_valid", 32'(rsp_valid1), 0);
    repeat (4) @(negedge clk);
    check("mrst_no_write", 32'(wr_total - wr_before), 0);
    check("mrst_mem", mem1[2], 32'hBEEFAA44);
    check("never_both", 32'(both_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
